layer_sequencer: RTL and testbench



---
 rtl/layer_sequencer.sv | 130 +++++++++++++
 tb/tb_layer_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Collects one layer's parallel neuron outputs into a holding buffer, then
// streams them out one word per handshake in neuron index order.
module layer_sequencer #(
    parameter int unsigned NUM_NEURONS = 30,
    parameter int unsigned DATAWIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_NEURONS-1:0]          in_valid,
    input  logic [DATAWIDTH*NUM_NEURONS-1:0] in_data,
    input  logic                            out_ready,
    output logic [DATAWIDTH-1:0]            out_data,
    output logic                            out_valid,
    output logic                            out_last,
    output logic                            busy,
    output logic                            layer_done,
    output logic                            overrun
);

    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic {
        COLLECT,
        SEND
    } state_t;

    state_t                 state, state_n;
    logic [NUM_NEURONS-1:0] mask, mask_n;
    logic [DATAWIDTH-1:0]   data_buf   [NUM_NEURONS];
    logic [DATAWIDTH-1:0]   data_buf_n [NUM_NEURONS];
    logic [IDX_W-1:0]       idx, idx_n, idx_inc;
    logic [DATAWIDTH-1:0]   out_data_n;
    logic                   out_valid_n, out_last_n, busy_n, layer_done_n, overrun_n;

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            mask       <= '0;
            idx        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            mask       <= mask_n;
            idx        <= idx_n;
            out_data   <= out_data_n;
            out_valid  <= out_valid_n;
            out_last   <= out_last_n;
            busy       <= busy_n;
            layer_done <= layer_done_n;
            overrun    <= overrun_n;
        end
    end

    // Holding buffer carries no reset; the capture mask qualifies its contents
    always_ff @(posedge clk) begin
        data_buf <= data_buf_n;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n      = state;
        mask_n       = mask;
        data_buf_n   = data_buf;
        idx_n        = idx;
        out_data_n   = out_data;
        out_valid_n  = out_valid;
        out_last_n   = out_last;
        busy_n       = busy;
        layer_done_n = 1'b0;
        overrun_n    = overrun;
        idx_inc      = idx + IDX_W'(1);

        case (state)
            COLLECT: begin
                for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                    if (in_valid[i]) begin
                        if (mask[i]) begin
                            overrun_n = 1'b1;
                        end else begin
                            data_buf_n[i] = in_data[i*DATAWIDTH +: DATAWIDTH];
                            mask_n[i]     = 1'b1;
                        end
                    end
                end
                // Bypass the freshly captured word 0 so it appears right after the last strobe
                if (&mask_n) begin
                    state_n     = SEND;
                    idx_n       = '0;
                    out_valid_n = 1'b1;
                    busy_n      = 1'b1;
                    out_last_n  = 1'b0;
                    out_data_n  = data_buf_n[0];
                end
            end

            SEND: begin
                if (|in_valid) begin
                    overrun_n = 1'b1;
                end
                if (out_valid && out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_n      = COLLECT;
                        mask_n       = '0;
                        idx_n        = '0;
                        out_valid_n  = 1'b0;
                        out_last_n   = 1'b0;
                        busy_n       = 1'b0;
                        layer_done_n = 1'b1;
                    end else begin
                        idx_n      = idx_inc;
                        out_data_n = data_buf[idx_inc];
                        out_last_n = (idx_inc == LAST_IDX);
                    end
                end
            end

            default: begin
                state_n = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes the expected word
// stream, an independent monitor pops and compares on each handshake.
module tb_layer_sequencer;

    localparam int unsigned N  = 30;
    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [DW*N-1:0]   in_data;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              layer_done;
    logic              overrun;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            exp_overrun = 1'b0;
    int            ready_mode  = 0;
    logic [DW-1:0] frame_vals [N];

    layer_sequencer #(.NUM_NEURONS(N), .DATAWIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy),
        .layer_done (layer_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random
    initial begin
        int phase;
        phase     = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = (phase == 0); phase = (phase + 1) % 3; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare each presented/accepted word against the scoreboard
    initial begin
        bit   done_pend;
        bit   stall_pend;
        exp_t e;
        done_pend  = 1'b0;
        stall_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_pend  = 1'b0;
                stall_pend = 1'b0;
            end else begin
                if (layer_done || done_pend) check("layer_done", 32'(layer_done), 32'(done_pend));
                done_pend = 1'b0;
                if (stall_pend) check("hold_valid", 32'(out_valid), 32'd1);
                stall_pend = 1'b0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_valid: out_valid=1 out_data=0x%0h with no word expected (t=%0t)", out_data, $time);
                    end else if (out_ready) begin
                        e = exp_q.pop_front();
                        check("word", 32'(out_data), 32'(e.data));
                        check("last", 32'(out_last), 32'(e.last));
                        if (e.last) done_pend = 1'b1;
                    end else begin
                        check("stall_data", 32'(out_data), 32'(exp_q[0].data));
                        stall_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = '0;
        exp_q.delete();
        exp_overrun = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_layer_done", 32'(layer_done), 32'd0);
        check("rst_overrun",    32'(overrun),    32'd0);
        check("rst_out_data",   32'(out_data),   32'd0);
    endtask

    // style: 0 = all strobes in one cycle, 1 = one per cycle highest first, 2 = random groups
    task automatic collect_frame(input int style, input bit dup7);
        logic [N-1:0] rem, v, dupm;
        int           hi, cyc;
        rem = '1;
        cyc = 0;
        if (dup7) begin
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'($urandom);
            in_valid = '0;
            in_valid[7] = 1'b1;
            in_data[7*DW +: DW] = frame_vals[7];
            @(posedge clk); #1;
            in_data[7*DW +: DW] = 16'hABCD;
            @(posedge clk); #1;
            exp_overrun = 1'b1;
            rem[7] = 1'b0;
        end
        while (rem != '0) begin
            dupm = '0;
            case (style)
                0: v = rem;
                1: begin
                    hi = 0;
                    for (int i = 0; i < N; i++) if (rem[i]) hi = i;
                    v = '0;
                    v[hi] = 1'b1;
                end
                default: begin
                    v    = (cyc > 40) ? rem : (rem & N'($urandom));
                    dupm = ~rem & N'($urandom) & N'($urandom) & N'($urandom);
                end
            endcase
            for (int i = 0; i < N; i++) begin
                in_data[i*DW +: DW] = v[i] ? frame_vals[i] : DW'($urandom);
            end
            if (dupm != '0) exp_overrun = 1'b1;
            in_valid = v | dupm;
            rem = rem & ~v;
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = '0;
        for (int i = 0; i < N; i++) exp_q.push_back('{data: frame_vals[i], last: (i == N - 1)});
    endtask

    // Wait for the scoreboard to drain; ends one cycle after the last accept
    task automatic drain(input bit check_latency, input bit check_busy);
        int cnt, cyc;
        cnt = 0;
        cyc = 0;
        if (check_latency) check("latency_valid", 32'(out_valid), 32'd1);
        while (exp_q.size() != 0 && cyc < 2000) begin
            if (busy) cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
            exp_q.delete();
        end
        if (check_busy) check("busy_cycles", 32'(cnt), 32'(N));
        check("end_busy",      32'(busy),      32'd0);
        check("end_out_valid", 32'(out_valid), 32'd0);
        check("overrun",       32'(overrun),   32'(exp_overrun));
    endtask

    task automatic random_vals();
        for (int i = 0; i < N; i++) frame_vals[i] = DW'($urandom);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = '0;
        in_data  = '0;
        do_reset();

        // Simultaneous capture
        for (int i = 0; i < N; i++) frame_vals[i] = 16'h0100 + DW'(i);
        collect_frame(0, 1'b0);
        drain(1'b1, 1'b1);

        // Skewed strobes, highest neuron first, started in the layer_done cycle
        for (int i = 0; i < N; i++) frame_vals[i] = 16'hF000 | DW'(i);
        collect_frame(1, 1'b0);
        drain(1'b1, 1'b1);

        // Backpressure
        ready_mode = 1;
        random_vals();
        collect_frame(0, 1'b0);
        drain(1'b1, 1'b0);

        // Overrun while the third word is presented
        ready_mode = 0;
        @(posedge clk); #1;
        random_vals();
        collect_frame(0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_data[5*DW +: DW] = DW'($urandom);
        in_valid[5] = 1'b1;
        @(posedge clk); #1;
        in_valid = '0;
        exp_overrun = 1'b1;
        check("overrun_set", 32'(overrun), 32'd1);
        drain(1'b0, 1'b0);

        // Overrun stays set through a later frame
        random_vals();
        collect_frame(2, 1'b0);
        drain(1'b1, 1'b1);

        // Reset after the 10th accepted word
        random_vals();
        collect_frame(0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_q.delete();
        exp_overrun = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_overrun",   32'(overrun),   32'd0);
        random_vals();
        collect_frame(2, 1'b0);
        drain(1'b1, 1'b1);

        // Duplicate strobe on neuron 7 keeps the first value
        random_vals();
        frame_vals[7] = 16'h1234;
        collect_frame(0, 1'b1);
        drain(1'b1, 1'b1);

        // Randomized frames under random downstream ready
        do_reset();
        for (int f = 0; f < 8; f++) begin
            ready_mode = int'($urandom_range(0, 2));
            @(posedge clk); #1;
            random_vals();
            collect_frame(2, 1'b0);
            drain(1'b1, ready_mode == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
